sram_program_loader: RTL

//  Upstream bus master that preloads a program image into external SRAM before the SLC-3 runs.

---
 rtl/slc3_pkg.sv | 50 +++++
 rtl/sram_program_loader_if.sv | 26 ++
 rtl/sram_bus_mux.sv | 21 ++
 rtl/sram_program_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 SRAM definitions: bus widths, loader FSM states, the bundled
// SRAM bus record and small arithmetic helpers.
package slc3_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int WORD_W      = 16;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_WSETUP = 4'd2,
      ST_WPULSE = 4'd3,
      ST_WHOLD  = 4'd4,
      ST_VFETCH = 4'd5,
      ST_VREAD1 = 4'd6,
      ST_VREAD2 = 4'd7,
      ST_VCMP   = 4'd8,
      ST_DONE   = 4'd9
   } loader_state_t;

   typedef struct packed {
      logic                   ce;
      logic                   ub;
      logic                   lb;
      logic                   oe;
      logic                   we;
      logic [SRAM_ADDR_W-1:0] addr;
      logic [WORD_W-1:0]      data;
      logic                   drive;
   } sram_bus_t;

   // All strobes deasserted (active-low) and the data bus released.
   localparam sram_bus_t BUS_IDLE = '{
      ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1,
      addr: {SRAM_ADDR_W{1'b0}}, data: {WORD_W{1'b0}}, drive: 1'b0
   };

   function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // 16-bit wrapping word address with the upper SRAM address bits held at zero.
   function automatic logic [SRAM_ADDR_W-1:0] word_addr(input logic [15:0] base,
                                                        input logic [15:0] idx);
      logic [15:0] a;
      a = base + idx;
      return {4'h0, a};
   endfunction

endpackage

// File: rtl/sram_program_loader_if.sv
// SRAM pin bundle. The master drives strobes/address/write data and receives
// the registered read data; the slave is the opposite view.
interface sram_program_loader_if;
   import slc3_pkg::*;

   logic                   CE;
   logic                   UB;
   logic                   LB;
   logic                   OE;
   logic                   WE;
   logic [SRAM_ADDR_W-1:0] ADDR;
   logic [WORD_W-1:0]      Data_write;
   logic                   tristate_output_enable;
   logic [WORD_W-1:0]      Data_read;

   modport master (
      output CE, UB, LB, OE, WE, ADDR, Data_write, tristate_output_enable,
      input  Data_read
   );

   modport slave (
      input  CE, UB, LB, OE, WE, ADDR, Data_write, tristate_output_enable,
      output Data_read
   );

endinterface

// File: rtl/sram_bus_mux.sv
// Selects which side owns the SRAM pins: the loader while it is busy, the CPU
// otherwise. Purely combinational so ownership flips on the same edge as Busy.
module sram_bus_mux
   import slc3_pkg::*;
(
   input  logic      sel_loader_i,
   input  sram_bus_t loader_i,
   input  sram_bus_t cpu_i,
   output sram_bus_t bus_o
);

   // Bus ownership select
   always_comb begin
      if (sel_loader_i) begin
         bus_o = loader_i;
      end else begin
         bus_o = cpu_i;
      end
   end

endmodule

// File: rtl/sram_program_loader.sv
// Copies a program image from a synchronous ROM into external SRAM before the
// SLC-3 starts, optionally reading every word back and counting mismatches.
module sram_program_loader
   import slc3_pkg::*;
#(
   parameter logic [15:0] START_ADDR = 16'h0000,
   parameter int          NUM_WORDS  = 256,
   parameter int          WE_CYCLES  = 2,
   parameter bit          VERIFY     = 1'b1
)(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   output logic [15:0]            prog_addr,
   input  logic [WORD_W-1:0]      prog_data,
   sram_program_loader_if.slave   cpu,
   sram_program_loader_if.master  sram,
   output logic                   Busy,
   output logic                   Done,
   output logic [15:0]            Error_count
);

   localparam int             IDX_W    = $clog2(NUM_WORDS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [3:0]     WE_LOAD  = 4'(WE_CYCLES - 1);

   loader_state_t     state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [3:0]        we_cnt_q;
   logic [WORD_W-1:0] word_q;
   logic [15:0]       prog_addr_q;
   logic              busy_q;
   logic              done_q;
   logic [15:0]       err_q;
   sram_bus_t         ld_q;

   logic [IDX_W-1:0]       idx_plus1;
   logic [SRAM_ADDR_W-1:0] cur_addr;
   logic                   cmp_err;
   sram_bus_t              cpu_bus;
   sram_bus_t              pin_bus;

   assign idx_plus1 = idx_q + IDX_W'(1);
   assign cur_addr  = word_addr(START_ADDR, 16'(idx_q));
   assign cmp_err   = (sram.Data_read != word_q);

   // Loader-owned SRAM cycle with CE and both byte lanes enabled.
   function automatic sram_bus_t bus_cycle(input logic [SRAM_ADDR_W-1:0] a,
                                           input logic [WORD_W-1:0] d,
                                           input logic oe, input logic we,
                                           input logic drive);
      return '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: oe, we: we,
               addr: a, data: d, drive: drive};
   endfunction

   // Load sequencer: state, word index, WE pulse timer, verify counter and pin drive
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= {IDX_W{1'b0}};
         we_cnt_q    <= 4'h0;
         word_q      <= 16'h0000;
         prog_addr_q <= 16'h0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 16'h0000;
         ld_q        <= BUS_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  state_q     <= ST_FETCH;
                  idx_q       <= {IDX_W{1'b0}};
                  prog_addr_q <= 16'h0000;
                  err_q       <= 16'h0000;
                  done_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  ld_q        <= BUS_IDLE;
               end
            end
            ST_FETCH: begin
               state_q <= ST_WSETUP;
               ld_q    <= bus_cycle(cur_addr, word_q, 1'b1, 1'b1, 1'b1);
            end
            // ROM data for prog_addr arrives here, one clock after FETCH.
            ST_WSETUP: begin
               state_q  <= ST_WPULSE;
               word_q   <= prog_data;
               we_cnt_q <= WE_LOAD;
               ld_q     <= bus_cycle(cur_addr, prog_data, 1'b1, 1'b0, 1'b1);
            end
            ST_WPULSE: begin
               if (we_cnt_q == 4'h0) begin
                  state_q <= ST_WHOLD;
                  ld_q    <= bus_cycle(cur_addr, word_q, 1'b1, 1'b1, 1'b1);
               end else begin
                  we_cnt_q <= we_cnt_q - 4'h1;
               end
            end
            ST_WHOLD: begin
               ld_q <= BUS_IDLE;
               if (idx_q == LAST_IDX) begin
                  idx_q       <= {IDX_W{1'b0}};
                  prog_addr_q <= 16'h0000;
                  if (VERIFY) begin
                     state_q <= ST_VFETCH;
                  end else begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  idx_q       <= idx_plus1;
                  prog_addr_q <= 16'(idx_plus1);
                  state_q     <= ST_FETCH;
               end
            end
            ST_VFETCH: begin
               state_q <= ST_VREAD1;
               ld_q    <= bus_cycle(cur_addr, word_q, 1'b0, 1'b1, 1'b0);
            end
            ST_VREAD1: begin
               state_q <= ST_VREAD2;
               word_q  <= prog_data;
            end
            // Data_read is registered, so VCMP sees the pins as driven in VREAD2.
            ST_VREAD2: begin
               state_q <= ST_VCMP;
               ld_q    <= BUS_IDLE;
            end
            ST_VCMP: begin
               if (cmp_err) begin
                  err_q <= sat_inc(err_q);
               end
               if (idx_q == LAST_IDX) begin
                  idx_q   <= {IDX_W{1'b0}};
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q       <= idx_plus1;
                  prog_addr_q <= 16'(idx_plus1);
                  state_q     <= ST_VFETCH;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ld_q    <= BUS_IDLE;
            end
         endcase
      end
   end

   assign cpu_bus = '{ce: cpu.CE, ub: cpu.UB, lb: cpu.LB, oe: cpu.OE, we: cpu.WE,
                      addr: cpu.ADDR, data: cpu.Data_write,
                      drive: cpu.tristate_output_enable};

   sram_bus_mux u_mux (
      .sel_loader_i (busy_q),
      .loader_i     (ld_q),
      .cpu_i        (cpu_bus),
      .bus_o        (pin_bus)
   );

   assign sram.CE                     = pin_bus.ce;
   assign sram.UB                     = pin_bus.ub;
   assign sram.LB                     = pin_bus.lb;
   assign sram.OE                     = pin_bus.oe;
   assign sram.WE                     = pin_bus.we;
   assign sram.ADDR                   = pin_bus.addr;
   assign sram.Data_write             = pin_bus.data;
   assign sram.tristate_output_enable = pin_bus.drive;
   assign cpu.Data_read               = sram.Data_read;

   assign prog_addr   = prog_addr_q;
   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Error_count = err_q;

endmodule
